// File: rtl/spi_slave_shift_reg_pkg.sv
// spi_slave_shift_reg_pkg
//   Shared constants, FSM state type and bit-selection helpers for the
//   SPI responder shift register.
//   - SPI_MAX_CHAR      : widest character in bits (also the tx/rx word width)
//   - SPI_CHAR_LEN_BITS : width of the len field (0 encodes SPI_MAX_CHAR)
//   - SPI_CNT_BITS      : width of the bit counter, which must reach SPI_MAX_CHAR
package spi_slave_shift_reg_pkg;

  localparam int SPI_MAX_CHAR      = 32;
  localparam int SPI_CHAR_LEN_BITS = 5;
  localparam int SPI_CNT_BITS      = 6;

  typedef enum logic {
    SPI_SLV_IDLE   = 1'b0,
    SPI_SLV_ACTIVE = 1'b1
  } spi_slv_state_e;

  // A len of zero means a full-width character.
  function automatic logic [SPI_CNT_BITS-1:0] char_bits(
    input logic [SPI_CHAR_LEN_BITS-1:0] len
  );
    return (len == '0) ? SPI_CNT_BITS'(SPI_MAX_CHAR) : {1'b0, len};
  endfunction

  // Bit of a right-aligned character that goes out in slot idx.
  // MSB-first starts from bit nbits-1, LSB-first from bit 0.
  function automatic logic pick_bit(
    input logic [SPI_MAX_CHAR-1:0]      word,
    input logic [SPI_CHAR_LEN_BITS-1:0] idx,
    input logic                         lsb_first,
    input logic [SPI_CNT_BITS-1:0]      nbits
  );
    logic [SPI_CHAR_LEN_BITS-1:0] pos;
    pos = lsb_first ? idx
                    : SPI_CHAR_LEN_BITS'(nbits - {1'b0, idx} - SPI_CNT_BITS'(1));
    return word[pos];
  endfunction

endpackage

// File: rtl/spi_slave_sync.sv
// spi_slave_sync
//   Multi-flop synchronizer for an asynchronous pad, followed by a delay
//   flop that turns level changes into registered one-cycle pulses.
//   Pulse latency from the pad edge is STAGES+1 clock cycles.
//   Parameters: STAGES (2 or 3), RESET_VAL (idle level of the pad)
//   Ports:
//     wb_clk_in  in  system clock
//     wb_rst_n   in  asynchronous active-low reset
//     pad        in  asynchronous input
//     rise       out one-cycle pulse on a synchronized 0->1 transition
//     fall       out one-cycle pulse on a synchronized 1->0 transition
module spi_slave_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic wb_clk_in,
  input  logic wb_rst_n,
  input  logic pad,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              dly;

  // Resetting to the idle level keeps reset release from looking like an edge.
  always_ff @(posedge wb_clk_in or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      chain <= {STAGES{RESET_VAL}};
      dly   <= RESET_VAL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], pad};
      dly   <= chain[STAGES-1];
      rise  <= chain[STAGES-1] & ~dly;
      fall  <= ~chain[STAGES-1] & dly;
    end
  end

endmodule

// File: rtl/spi_slave_shift_reg.sv
// spi_slave_shift_reg
//   SPI responder datapath. Oversamples sclk/ss/mosi in the wb_clk_in
//   domain, shifts in characters of 1..32 bits in any CPOL/CPHA mode and
//   shifts out a word preloaded into a one-entry tx buffer.
//   Optional macro SPI_SLAVE_OVERRUN_EN: when defined, a character that
//   completes while rx_valid is still set is dropped and rx_overrun is set;
//   when undefined, the new character overwrites rx_data.
//   Ports:
//     wb_clk_in, wb_rst_n           clock, async active-low reset
//     sclk_pad_i, ss_pad_i          SPI clock and active-low select pads
//     mosi_pad_i, miso_pad_o        serial data in / out
//     miso_oe_o                     miso enable, high while selected
//     cpol, cpha, lsb, len          character format (static while selected)
//     tx_data, tx_load, tx_empty    tx buffer write port and status
//     rx_data, rx_valid, rx_ack     received character handshake
//     rx_overrun                    sticky overrun flag
//     tip                           character partially shifted
module spi_slave_shift_reg
  import spi_slave_shift_reg_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                         wb_clk_in,
  input  logic                         wb_rst_n,
  input  logic                         sclk_pad_i,
  input  logic                         ss_pad_i,
  input  logic                         mosi_pad_i,
  output logic                         miso_pad_o,
  output logic                         miso_oe_o,
  input  logic                         cpol,
  input  logic                         cpha,
  input  logic                         lsb,
  input  logic [SPI_CHAR_LEN_BITS-1:0] len,
  input  logic [SPI_MAX_CHAR-1:0]      tx_data,
  input  logic                         tx_load,
  output logic                         tx_empty,
  output logic [SPI_MAX_CHAR-1:0]      rx_data,
  output logic                         rx_valid,
  input  logic                         rx_ack,
  output logic                         rx_overrun,
  output logic                         tip
);

  spi_slv_state_e state_q, state_d;

  logic sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic mosi_s;

  logic [SPI_MAX_CHAR-1:0]      tx_buf, tx_sr, rx_sr, rx_shifted, load_word;
  logic [SPI_CNT_BITS-1:0]      bit_cnt, nbits;
  logic [SPI_CHAR_LEN_BITS-1:0] tx_cnt;
  logic lead_edge, trail_edge, sample_edge, launch_edge;
  logic frame_start, frame_abort, do_sample, do_launch, char_done, consume;

  spi_slave_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .wb_clk_in (wb_clk_in),
    .wb_rst_n  (wb_rst_n),
    .pad       (sclk_pad_i),
    .rise      (sclk_rise),
    .fall      (sclk_fall)
  );

  spi_slave_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ss_sync (
    .wb_clk_in (wb_clk_in),
    .wb_rst_n  (wb_rst_n),
    .pad       (ss_pad_i),
    .rise      (ss_rise),
    .fall      (ss_fall)
  );

  // mosi goes through the same depth as sclk so it stays aligned with the
  // edge pulses; it only needs the level, not edge detection.
  always_ff @(posedge wb_clk_in or negedge wb_rst_n) begin
    if (!wb_rst_n) mosi_sync <= '0;
    else           mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_pad_i};
  end

  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign lead_edge   = cpol ? sclk_fall : sclk_rise;
  assign trail_edge  = cpol ? sclk_rise : sclk_fall;
  assign sample_edge = cpha ? trail_edge : lead_edge;
  assign launch_edge = cpha ? lead_edge  : trail_edge;

  assign nbits       = char_bits(len);
  assign load_word   = tx_empty ? '0 : tx_buf;
  assign frame_start = (state_q == SPI_SLV_IDLE) && ss_fall;
  assign frame_abort = (state_q == SPI_SLV_ACTIVE) && ss_rise;
  assign do_sample   = (state_q == SPI_SLV_ACTIVE) && !ss_rise && sample_edge;
  assign do_launch   = (state_q == SPI_SLV_ACTIVE) && !ss_rise && launch_edge;
  assign char_done   = do_sample && ((bit_cnt + SPI_CNT_BITS'(1)) == nbits);
  assign consume     = frame_start || char_done;
  assign miso_oe_o   = (state_q == SPI_SLV_ACTIVE);

  // The receive register is cleared at each character start, so both
  // orders leave the character right-aligned with zero upper bits.
  always_comb begin
    rx_shifted = rx_sr;
    if (lsb) rx_shifted[bit_cnt[SPI_CHAR_LEN_BITS-1:0]] = mosi_s;
    else     rx_shifted = {rx_sr[SPI_MAX_CHAR-2:0], mosi_s};
  end

  // State register.
  always_ff @(posedge wb_clk_in or negedge wb_rst_n) begin
    if (!wb_rst_n) state_q <= SPI_SLV_IDLE;
    else           state_q <= state_d;
  end

  // Selection follows the synchronized ss edges only.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SPI_SLV_IDLE:   if (ss_fall) state_d = SPI_SLV_ACTIVE;
      SPI_SLV_ACTIVE: if (ss_rise) state_d = SPI_SLV_IDLE;
      default:        state_d = SPI_SLV_IDLE;
    endcase
  end

  // One-entry tx buffer. A load in the same cycle as a consume wins: the
  // consume has already taken the old word through load_word.
  always_ff @(posedge wb_clk_in or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      tx_buf   <= '0;
      tx_empty <= 1'b1;
    end else if (tx_load) begin
      tx_buf   <= tx_data;
      tx_empty <= 1'b0;
    end else if (consume) begin
      tx_empty <= 1'b1;
    end
  end

  // Shift datapath. With cpha=0 bit 0 goes out at selection and tx_cnt
  // points at the next slot; with cpha=1 the first launch edge sends bit 0.
  // A finished character reloads and rewinds tx_cnt so the next launch edge
  // carries bit 0 of the following character.
  always_ff @(posedge wb_clk_in or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      tx_sr      <= '0;
      rx_sr      <= '0;
      bit_cnt    <= '0;
      tx_cnt     <= '0;
      miso_pad_o <= 1'b0;
      tip        <= 1'b0;
    end else if (frame_start) begin
      tx_sr      <= load_word;
      rx_sr      <= '0;
      bit_cnt    <= '0;
      tip        <= 1'b0;
      tx_cnt     <= cpha ? SPI_CHAR_LEN_BITS'(0) : SPI_CHAR_LEN_BITS'(1);
      miso_pad_o <= cpha ? 1'b0 : pick_bit(load_word, '0, lsb, nbits);
    end else if (frame_abort) begin
      rx_sr      <= '0;
      bit_cnt    <= '0;
      tip        <= 1'b0;
      miso_pad_o <= 1'b0;
    end else begin
      if (do_sample) begin
        if (char_done) begin
          rx_sr   <= '0;
          bit_cnt <= '0;
          tip     <= 1'b0;
          tx_sr   <= load_word;
          tx_cnt  <= '0;
        end else begin
          rx_sr   <= rx_shifted;
          bit_cnt <= bit_cnt + SPI_CNT_BITS'(1);
          tip     <= 1'b1;
        end
      end
      if (do_launch) begin
        miso_pad_o <= pick_bit(tx_sr, tx_cnt, lsb, nbits);
        tx_cnt     <= tx_cnt + SPI_CHAR_LEN_BITS'(1);
      end
    end
  end

`ifdef SPI_SLAVE_OVERRUN_EN
  // Receive handshake: an unread character is protected, a newer one is
  // dropped and flagged. A completion beats a simultaneous acknowledge.
  always_ff @(posedge wb_clk_in or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end else if (char_done) begin
      if (rx_valid) rx_overrun <= 1'b1;
      else          rx_data    <= rx_shifted;
      rx_valid <= 1'b1;
    end else if (rx_ack) begin
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end
  end
`else
  // Receive handshake: the newest character always lands in rx_data. A
  // completion beats a simultaneous acknowledge.
  always_ff @(posedge wb_clk_in or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else if (char_done) begin
      rx_data  <= rx_shifted;
      rx_valid <= 1'b1;
    end else if (rx_ack) begin
      rx_valid <= 1'b0;
    end
  end

  assign rx_overrun = 1'b0;
`endif

endmodule

// File: doc/spi_slave_shift_reg.md
# spi_slave_shift_reg

SPI responder (slave) datapath for the far end of the link driven by our SPI master shift register. It samples the external sclk, ss and mosi pads in the wb_clk_in domain, shifts in characters of programmable length, and shifts out a preloaded transmit word on miso. The block supports all four CPOL/CPHA modes and presents received data to the Wishbone-side register block through a valid/ack handshake.

## Interface
- SYNC_STAGES, 2, number of flops in each pad synchronizer; legal values are 2 or 3.
- wb_clk_in  in  1  system clock; all logic runs on the rising edge.
- wb_rst_n  in  1  asynchronous, active-low reset.
- sclk_pad_i  in  1  SPI clock from the master.
- ss_pad_i  in  1  slave select, active low.
- mosi_pad_i  in  1  serial data from the master.
- miso_pad_o  out  1  serial data to the master.
- miso_oe_o  out  1  miso output enable; high while the block is selected.
- cpol  in  1  idle level of sclk.
- cpha  in  1  0 = sample on the leading edge; 1 = sample on the trailing edge.
- lsb  in  1  1 = LSB first; 0 = MSB first.
- len  in  `SPI_CHAR_LEN_BITS  character length in bits; 0 encodes `SPI_MAX_CHAR.
- tx_data  in  `SPI_MAX_CHAR  word for the next character.
- tx_load  in  1  one-cycle strobe that writes tx_data into the tx buffer.
- tx_empty  out  1  tx buffer holds no unsent word.
- rx_data  out  `SPI_MAX_CHAR  last received character, right-aligned.
- rx_valid  out  1  rx_data holds an unread character.
- rx_ack  in  1  one-cycle strobe that clears rx_valid.
- rx_overrun  out  1  sticky overrun flag (see Configuration).
- tip  out  1  transfer in progress: a character is partially shifted.

## Operation
- The sclk and ss pads are synchronized through SYNC_STAGES flops, then a delay flop produces edge pulses. mosi is synchronized with the same depth so that it stays aligned with sclk.
- Leading edge: rising when cpol=0, falling when cpol=1. The other edge is the trailing edge.
- The sample edge is the leading edge when cpha=0 and the trailing edge when cpha=1. The launch edge is the opposite edge.
- FSM states are IDLE and ACTIVE.
- IDLE -> ACTIVE on a synchronized ss falling edge:
  - load the shift register from the tx buffer; load zeros if the buffer is empty;
  - clear the bit counter;
  - set tx_empty;
  - assert miso_oe_o;
  - when cpha=0, drive the first bit on miso immediately.
- ACTIVE, sample edge: shift mosi in at the bit position selected by lsb, increment the bit counter, and set tip.
- ACTIVE, launch edge: present the next bit on miso. When cpha=1, the first launch edge presents bit 0 of the character.
- Character complete (bit counter = len):
  - rx_data <= the received bits, right-aligned, with upper bits zero;
  - set rx_valid and clear tip;
  - reload the shift register from the tx buffer for back-to-back characters.
- ss rising edge in any state: go to IDLE, discard any partial character (rx_data unchanged), clear tip, deassert miso_oe_o.
- Changing cpol, cpha, lsb or len while ACTIVE is unsupported; those inputs may only change while ss is high.
- tx_load coinciding with a buffer consume: the consume takes the old contents, the new tx_data is stored, and tx_empty ends at 0.
- rx_ack coinciding with a character completion: the set wins, and rx_valid remains 1.
- tx_load while the buffer is full overwrites the buffer.

## Timing
- Reset values: miso_pad_o=0, miso_oe_o=0, tx_empty=1, rx_data=0, rx_valid=0, rx_overrun=0, tip=0, FSM=IDLE.
- Pad-to-edge-pulse latency is SYNC_STAGES+1 wb_clk_in cycles.
- miso updates 1 cycle after the launch-edge pulse, so it settles SYNC_STAGES+2 cycles after the pad edge.
- rx_valid rises 1 cycle after the final sample-edge pulse.
- Requirements:
  - sclk half-period >= SYNC_STAGES+3 wb_clk_in cycles, which gives a minimum ratio of 10x at SYNC_STAGES=2;
  - ss setup to the first sclk edge >= one sclk half-period.
- rx_ack clears rx_valid on the following cycle.

## Configuration
- Macro: `SPI_SLAVE_OVERRUN_EN`.
- Defined: when a character completes while rx_valid=1, the new character is dropped, rx_data is kept, and rx_overrun is set. rx_overrun clears with rx_ack.
- Undefined: a new character overwrites rx_data, and rx_overrun is tied to 0.

## Structure
- spi_defines.v holds:
  - existing `SPI_MAX_CHAR and `SPI_CHAR_LEN_BITS;
  - new state encodings `SPI_SLV_IDLE and `SPI_SLV_ACTIVE.
- Sub-module spi_slave_sync: a SYNC_STAGES synchronizer with rise and fall pulse outputs. Instantiate it for sclk and ss; mosi uses the plain synchronized output.

## Test plan
- Mode 0, len=8, lsb=0, tx_load 8'hA5; master sends 8'h3C -> master receives 8'hA5, rx_data=32'h3C, rx_valid pulses high and is held, tip low afterwards.
- Mode 3, len=4, lsb=1; master sends 4'b1010 LSB first -> rx_data=32'hA; first miso bit appears only after the first launch edge.
- Back-to-back transfer, len=0 (32 bits), tx words 32'hDEADBEEF then 32'h12345678 loaded mid-frame -> both words seen on miso in order, with two rx completions.
- ss deasserted after 5 of 8 bits -> FSM returns to IDLE, rx_valid stays 0, rx_data unchanged, miso_oe_o low within SYNC_STAGES+2 cycles.
- Two characters without rx_ack, with the macro defined -> rx_overrun=1 and rx_data equals the first character; rx_ack clears both flags. Without the macro, rx_data equals the second character.
- Assert wb_rst_n=0 mid-character -> every output returns to its reset value asynchronously; the next ss assertion transfers cleanly.
